// File: rtl/tcam_match_enumerator.sv
// Walks a captured TCAM hit vector and hands out every matching entry index,
// lowest first, over a valid/ready interface, with match count and no-match pulse.
module tcam_match_enumerator #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hits_valid,
   input  logic [ENTRIES-1:0] hits,
   input  logic               flush,
   output logic               busy,
   output logic               idx_valid,
   output logic [IDX_W-1:0]   idx,
   output logic               idx_last,
   input  logic               idx_ready,
   output logic               no_match,
   output logic [IDX_W:0]     match_count
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ENTRIES-1:0] pending_q, pending_d;
   logic [IDX_W:0]     count_q, count_d;
   logic               no_match_q, no_match_d;
   logic [IDX_W-1:0]   low_idx_s;
   logic               single_s;

   function automatic logic [IDX_W:0] popcount(input logic [ENTRIES-1:0] v);
      logic [IDX_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         cnt = cnt + (IDX_W+1)'(v[i]);
      end
      return cnt;
   endfunction

   // Scan from the top so the lowest set bit is the last one written.
   function automatic logic [IDX_W-1:0] lowest_index(input logic [ENTRIES-1:0] v);
      logic [IDX_W-1:0] res;
      res = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (v[i]) begin
            res = IDX_W'(i);
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Index and last flag derived purely from registered pending state.
   always_comb begin
      low_idx_s = lowest_index(pending_q);
      single_s  = (pending_q != '0) && ((pending_q & (pending_q - ENTRIES'(1))) == '0);
   end

   // Next-state logic: capture in IDLE, pop or flush in EMIT.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      count_d    = count_q;
      no_match_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (hits_valid && !flush) begin
               count_d = popcount(hits);
               if (hits != '0) begin
                  pending_d = hits;
                  state_d   = EMIT;
               end else begin
                  no_match_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (flush) begin
               pending_d = '0;
               state_d   = IDLE;
            end else if (idx_ready) begin
               pending_d = pending_q & (pending_q - ENTRIES'(1));
               if (single_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = EMIT;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            pending_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         count_q    <= '0;
         no_match_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         count_q    <= count_d;
         no_match_q <= no_match_d;
      end
   end

   assign busy        = (state_q == EMIT);
   assign idx_valid   = (state_q == EMIT);
   assign idx         = low_idx_s;
   assign idx_last    = (state_q == EMIT) && single_s;
   assign no_match    = no_match_q;
   assign match_count = count_q;

endmodule

// File: tb/tb_tcam_match_enumerator.sv
// Directed and random stimulus for tcam_match_enumerator, checked against a
// queue-based reference model of the enumeration.
module tb_tcam_match_enumerator;

   logic        clk = 1'b0;
   logic        reset;
   logic        hits_valid;
   logic [15:0] hits;
   logic        flush;
   logic        busy;
   logic        idx_valid;
   logic [3:0]  idx;
   logic        idx_last;
   logic        idx_ready;
   logic        no_match;
   logic [4:0]  match_count;

   int n_err = 0;
   int n_checks = 0;

   int m_q[$];
   int m_count = 0;
   bit m_nm = 1'b0;

   tcam_match_enumerator #(.ENTRIES(16), .IDX_W(4)) dut (
      .clk(clk), .reset(reset), .hits_valid(hits_valid), .hits(hits),
      .flush(flush), .busy(busy), .idx_valid(idx_valid), .idx(idx),
      .idx_last(idx_last), .idx_ready(idx_ready), .no_match(no_match),
      .match_count(match_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check outputs mid-cycle, then advance the model.
   task automatic step(input logic rst, input logic hv, input logic [15:0] h,
                       input logic fl, input logic rdy);
      bit emitting;
      reset = rst; hits_valid = hv; hits = h; flush = fl; idx_ready = rdy;
      @(negedge clk);
      emitting = (m_q.size() != 0);
      chk("busy", 32'(busy), 32'(emitting));
      chk("idx_valid", 32'(idx_valid), 32'(emitting));
      chk("no_match", 32'(no_match), 32'(m_nm));
      chk("match_count", 32'(match_count), 32'(m_count));
      if (emitting) begin
         chk("idx", 32'(idx), 32'(m_q[0]));
         chk("idx_last", 32'(idx_last), 32'(m_q.size() == 1));
      end else begin
         chk("idx_last_idle", 32'(idx_last), 32'd0);
      end
      if (rst) begin
         m_q.delete(); m_count = 0; m_nm = 1'b0;
      end else begin
         m_nm = 1'b0;
         if (!emitting) begin
            if (hv && !fl) begin
               m_count = $countones(h);
               if (h == 16'h0000) m_nm = 1'b1;
               for (int i = 0; i < 16; i++) if (h[i]) m_q.push_back(i);
            end
         end else if (fl) begin
            m_q.delete();
         end else if (rdy) begin
            void'(m_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; hits_valid = 1'b0; hits = 16'h0000; flush = 1'b0; idx_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset held two cycles with random inputs
      step(1'b1, 1'($urandom), 16'($urandom), 1'b0, 1'($urandom));
      step(1'b1, 1'($urandom), 16'($urandom), 1'b0, 1'($urandom));
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("reset_idx", 32'(idx), 32'd0);
      // Reset mid-enumeration
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      // 0x0013 with ready held high
      step(1'b0, 1'b1, 16'h0013, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      // 0x8001 with back-pressure
      step(1'b0, 1'b1, 16'h8001, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      // Empty search
      step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      // All hits, with ignored search results during EMIT
      step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      // Flush mid-enumeration, then flush beats a capture in IDLE
      step(1'b0, 1'b1, 16'h00F0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [15:0] h;
         case ($urandom_range(3, 0))
            0: h = 16'h0000;
            1: h = 16'(1 << $urandom_range(15, 0));
            2: h = 16'($urandom) & 16'($urandom);
            default: h = 16'($urandom);
         endcase
         step(1'($urandom_range(49, 0) == 0), 1'($urandom_range(2, 0) == 0), h,
              1'($urandom_range(19, 0) == 0), 1'($urandom_range(3, 0) != 0));
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tcam_match_enumerator.md
Name: tcam_match_enumerator

Overview:
Downstream consumer of the 16-entry TCAM search result.
- Captures the TCAM hit vector on a search cycle.
- Emits the index of every matching entry, lowest index first, one per handshake over a valid/ready interface.
- Reports the match count and a no-match pulse.
- Lets the lookup/forwarding logic walk all matching entries, not just the highest-priority one.

Parameters:
ENTRIES, 16, number of TCAM entries (width of the hit vector).
IDX_W, 4, index width; must satisfy 2**IDX_W >= ENTRIES.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
hits_valid  input  1  hits is a valid search result this cycle; driven high on TCAM search cycles (TCAM write_enable=0).
hits  input  ENTRIES  TCAM hit vector; bit i set means entry i matched.
flush  input  1  synchronous abort of the current enumeration.
busy  output  1  enumeration in progress; hits_valid is ignored while high.
idx_valid  output  1  idx holds a valid match index.
idx  output  IDX_W  index of the current matching entry.
idx_last  output  1  current idx is the final match of this search.
idx_ready  input  1  consumer accepts idx this cycle.
no_match  output  1  one-cycle pulse: captured search had zero hits.
match_count  output  IDX_W+1  number of set bits in the last captured vector.

Behaviour:
- Reset (clk edge with reset=1) dominates everything.
  - State returns to IDLE; the pending register clears.
  - busy, idx_valid, idx_last, no_match are 0; idx is 0; match_count is 0.
  - Reset mid-enumeration discards all remaining indices with no further handshakes.
- Internal state: pending[ENTRIES-1:0] register; FSM states IDLE and EMIT.
- IDLE (busy=0, idx_valid=0):
  - hits_valid=1, flush=0, hits!=0: at that edge, pending<=hits, match_count<=popcount(hits), go to EMIT.
  - hits_valid=1, flush=0, hits==0: match_count<=0 and no_match=1 for exactly the next cycle; stay IDLE.
  - flush=1 with hits_valid=1: flush wins; nothing is captured and match_count is unchanged.
- EMIT (busy=1, idx_valid=1):
  - idx = position of the lowest set bit of pending.
  - idx_last=1 iff pending has exactly one bit set.
  - idx and idx_last are functions of registered state only, so they are stable while idx_valid && !idx_ready.
  - On an edge with idx_valid && idx_ready, the lowest set bit of pending clears.
  - If that bit was the last one: go to IDLE, and busy/idx_valid are 0 the following cycle.
  - hits_valid is ignored throughout EMIT, including the cycle of the final handshake. The earliest new capture is the first IDLE cycle.
  - flush=1: pending<=0 and go to IDLE. idx_valid is 0 the next cycle; no handshake completes on the flush edge. match_count holds.
- Latency: capture at edge N puts the first idx_valid in cycle N+1. With idx_ready held high, one index per cycle, so k matches take k cycles of EMIT.
- idx_ready while idx_valid=0 has no effect.
- match_count holds its value until the next capture. It is IDX_W+1 bits wide so that all 16 hits reads 5'b10000.
- Pure synchronous logic; no combinational path from hits to any output.

Test Plan:
1. Assert reset 2 cycles with random hits/hits_valid -> busy=0, idx_valid=0, no_match=0, idx=0, match_count=0. Repeat reset mid-EMIT -> idx_valid=0 the next cycle.
2. hits=16'h0013, hits_valid 1 cycle, idx_ready=1 -> idx 0,1,4 in three consecutive cycles; idx_last only with 4; match_count=3; busy low the cycle after.
3. hits=16'h8001, idx_ready=0 for 3 cycles -> idx=0 with idx_last=0 held stable all 3 cycles. Then idx_ready=1 -> idx 15 with idx_last=1.
4. hits=16'h0000 with hits_valid=1 -> no_match high exactly 1 cycle, match_count=0, idx_valid never asserts, busy stays 0.
5. hits=16'hFFFF, idx_ready=1 -> idx 0..15 over 16 cycles; idx_last only on 15; match_count=5'b10000. hits_valid=1 with hits=16'h0002 during EMIT is ignored.
6. hits=16'h00F0, accept idx 4 and 5, then flush=1 -> idx_valid=0 the next cycle; 6 and 7 never appear; match_count stays 4. In IDLE, flush=1 together with hits_valid=1 and hits=16'h0001 -> no capture.
